// File: rtl/sensor_monitor_pkg.sv
// sensor_monitor_pkg
// Shared definitions for the sensor monitor: the 2-bit debounce FSM state
// encoding and the default values of the top-level parameters.
// No ports.
package sensor_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RISE_CHK = 2'd1,
      ACTIVE   = 2'd2,
      FALL_CHK = 2'd3
   } state_t;

   localparam int DEB_LEN_DEF  = 4;
   localparam int CNT_W_DEF    = 8;
   localparam int ALARM_TH_DEF = 10;

endpackage

// File: rtl/sensor_monitor_if.sv
// sensor_monitor_if
// Bundles every sensor_monitor signal except clock and reset.
//   Z_IN      sensor level, asynchronous to the clock
//   CLR       synchronous clear of event count, ALARM (and OVF)
//   RD_REQ    snapshot request level; a 0->1 change requests one snapshot
//   RD_ACK    single-cycle pulse; COUNT is valid while it is high and is
//             held until the next snapshot
//   COUNT     snapshot of the event count
//   ALARM     sticky threshold flag
//   LVL       debounced level
//   dbg_state current debounce FSM state
//   OVF       sticky saturation flag (only with SENSOR_MONITOR_SAT_EN)
// Handshake: RD_REQ is a level with no ready; each rising edge seen on a
// clock edge is answered by exactly one RD_ACK pulse in the following cycle.
// Modports: master drives the inputs, slave is the monitor side.
// Macro: SENSOR_MONITOR_SAT_EN adds OVF.
interface sensor_monitor_if #(
   parameter int CNT_W = sensor_monitor_pkg::CNT_W_DEF
) ();
   import sensor_monitor_pkg::*;

   logic             Z_IN;
   logic             CLR;
   logic             RD_REQ;
   logic             RD_ACK;
   logic [CNT_W-1:0] COUNT;
   logic             ALARM;
   logic             LVL;
   state_t           dbg_state;
`ifdef SENSOR_MONITOR_SAT_EN
   logic             OVF;

   modport master (output Z_IN, CLR, RD_REQ,
                   input  RD_ACK, COUNT, ALARM, LVL, dbg_state, OVF);
   modport slave  (input  Z_IN, CLR, RD_REQ,
                   output RD_ACK, COUNT, ALARM, LVL, dbg_state, OVF);
`else
   modport master (output Z_IN, CLR, RD_REQ,
                   input  RD_ACK, COUNT, ALARM, LVL, dbg_state);
   modport slave  (input  Z_IN, CLR, RD_REQ,
                   output RD_ACK, COUNT, ALARM, LVL, dbg_state);
`endif

endinterface

// File: rtl/sensor_monitor_sync.sv
// sensor_sync
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst (async active-high, clears both flops), d (async in),
//        q (synchronised out).
module sensor_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/sensor_monitor.sv
// sensor_monitor
// Debounces a synchronised sensor level, counts accepted rising levels as
// events, raises a sticky ALARM at a threshold and offers a snapshot of the
// count through a RD_REQ/RD_ACK handshake.
// Ports: CLK (sole clock), MR (async active-high reset), bus
// (sensor_monitor_if.slave, all other signals).
// Parameters: DEB_LEN (1..15 consecutive samples), CNT_W (count width),
// ALARM_TH (event count that sets ALARM).
// Macro: SENSOR_MONITOR_SAT_EN makes the count saturate and adds sticky OVF;
// without it the count wraps and ALARM stays set across the wrap.
module sensor_monitor
   import sensor_monitor_pkg::*;
#(
   parameter int DEB_LEN  = DEB_LEN_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int ALARM_TH = ALARM_TH_DEF
) (
   input logic             CLK,
   input logic             MR,
   sensor_monitor_if.slave bus
);

   localparam logic [3:0]       DEB_TGT    = 4'(DEB_LEN);
   localparam logic [31:0]      ALARM_TH_U = ALARM_TH;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic             sample;
   state_t           state_q, state_d;
   logic [3:0]       deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] snap_q, snap_d;
   logic             alarm_q, alarm_d;
   logic             ack_q, ack_d;
   logic             req_q;
   logic             event_w;
   logic             req_rise;
`ifdef SENSOR_MONITOR_SAT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic             ovf_q, ovf_d;
`endif

   sensor_sync u_sync (
      .clk (CLK),
      .rst (MR),
      .d   (bus.Z_IN),
      .q   (sample)
   );

   always_ff @(posedge CLK or posedge MR) begin
      if (MR) begin
         state_q <= IDLE;
         deb_q   <= 4'd0;
         cnt_q   <= '0;
         snap_q  <= '0;
         alarm_q <= 1'b0;
         ack_q   <= 1'b0;
         req_q   <= 1'b0;
`ifdef SENSOR_MONITOR_SAT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         alarm_q <= alarm_d;
         ack_q   <= ack_d;
         req_q   <= bus.RD_REQ;
`ifdef SENSOR_MONITOR_SAT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Debounce FSM. deb counts consecutive samples at the pending level; the
   // state flips on the edge where deb would reach DEB_LEN, so a level held
   // from its first sampled edge is accepted on edge 2+DEB_LEN.
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      event_w = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample) begin
               if (DEB_TGT == 4'd1) begin
                  state_d = ACTIVE;
                  event_w = 1'b1;
               end else begin
                  state_d = RISE_CHK;
                  deb_d   = 4'd1;
               end
            end
         end
         RISE_CHK: begin
            if (!sample) begin
               state_d = IDLE;
               deb_d   = 4'd0;
            end else if (deb_q + 4'd1 == DEB_TGT) begin
               state_d = ACTIVE;
               deb_d   = 4'd0;
               event_w = 1'b1;
            end else begin
               deb_d = deb_q + 4'd1;
            end
         end
         ACTIVE: begin
            if (!sample) begin
               if (DEB_TGT == 4'd1) begin
                  state_d = IDLE;
               end else begin
                  state_d = FALL_CHK;
                  deb_d   = 4'd1;
               end
            end
         end
         FALL_CHK: begin
            if (sample) begin
               state_d = ACTIVE;
               deb_d   = 4'd0;
            end else if (deb_q + 4'd1 == DEB_TGT) begin
               state_d = IDLE;
               deb_d   = 4'd0;
            end else begin
               deb_d = deb_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            deb_d   = 4'd0;
         end
      endcase
   end

   // Event count and flags; CLR overrides an event landing on the same edge.
   always_comb begin
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
`ifdef SENSOR_MONITOR_SAT_EN
      ovf_d   = ovf_q;
`endif
      if (bus.CLR) begin
         cnt_d   = '0;
         alarm_d = 1'b0;
`ifdef SENSOR_MONITOR_SAT_EN
         ovf_d   = 1'b0;
`endif
      end else begin
         if (event_w) begin
`ifdef SENSOR_MONITOR_SAT_EN
            if (cnt_q == CNT_MAX) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
`else
            cnt_d = cnt_q + CNT_ONE;
`endif
         end
         if (32'(cnt_d) >= ALARM_TH_U) begin
            alarm_d = 1'b1;
         end
      end
   end

   // Snapshot takes the registered (pre-increment, pre-clear) count.
   always_comb begin
      req_rise = bus.RD_REQ & ~req_q;
      ack_d    = req_rise;
      snap_d   = req_rise ? cnt_q : snap_q;
   end

   assign bus.RD_ACK    = ack_q;
   assign bus.COUNT     = snap_q;
   assign bus.ALARM     = alarm_q;
   assign bus.LVL       = (state_q == ACTIVE) || (state_q == FALL_CHK);
   assign bus.dbg_state = state_q;
`ifdef SENSOR_MONITOR_SAT_EN
   assign bus.OVF       = ovf_q;
`endif

endmodule

// File: doc/sensor_monitor.md
SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 Parameter DEB_LEN, default 4, SHALL set the number of consecutive synchronised samples needed to accept a level change (legal range 1..15).
REQ-002 Parameter CNT_W, default 8, SHALL set the event-counter width.
REQ-003 Parameter ALARM_TH, default 10, SHALL set the event count at which ALARM asserts.
REQ-004 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 MR  in  1  reset; asynchronous and active-high.
REQ-006 Z_IN  in  1  level output of the upstream sensor stage; asynchronous to CLK.
REQ-007 CLR  in  1  synchronous clear of the event count and the ALARM flag.
REQ-008 RD_REQ  in  1  snapshot request (level).
REQ-009 RD_ACK  out  1  one-cycle snapshot-valid pulse.
REQ-010 COUNT  out  CNT_W  snapshot of the event count.
REQ-011 ALARM  out  1  sticky threshold flag.
REQ-012 LVL  out  1  debounced level of Z_IN.

Function
REQ-013 Z_IN SHALL pass through a 2-flop synchroniser; "sample" below means the second-flop output.
REQ-014 The FSM SHALL have the states IDLE (LVL=0), RISE_CHK, ACTIVE (LVL=1) and FALL_CHK; LVL SHALL be 1 only in ACTIVE and FALL_CHK.
REQ-015 In IDLE, a sample of 1 SHALL enter RISE_CHK with deb=1; in ACTIVE, a sample of 0 SHALL enter FALL_CHK with deb=1.
REQ-016 In RISE_CHK/FALL_CHK, a sample matching the pending level SHALL increment deb; when deb reaches DEB_LEN the FSM SHALL enter ACTIVE/IDLE respectively.
REQ-017 A mismatching sample in RISE_CHK/FALL_CHK SHALL return the FSM to IDLE/ACTIVE respectively and clear deb (glitch rejection).
REQ-018 If DEB_LEN=1, the FSM SHALL move IDLE->ACTIVE and ACTIVE->IDLE directly.
REQ-019 Each RISE_CHK->ACTIVE (or IDLE->ACTIVE) transition is one event; the event count SHALL increment on the same edge.
REQ-020 Latency: with Z_IN held high from its first sampled edge, LVL and the count SHALL update after edge 2+DEB_LEN.
REQ-021 ALARM SHALL set on the edge where the count becomes >= ALARM_TH and SHALL hold until CLR or MR.
REQ-022 CLR SHALL zero the count and ALARM on the next edge; CLR together with an event in the same cycle SHALL give count 0 (CLR wins).
REQ-023 A 0->1 transition of RD_REQ SHALL load COUNT with the pre-increment count and pulse RD_ACK high for exactly the following cycle.
REQ-024 A held RD_REQ SHALL not re-trigger; a new snapshot SHALL need RD_REQ low for at least one sampled cycle.
REQ-025 A snapshot coinciding with CLR SHALL capture the pre-clear value.

Reset
REQ-026 MR high SHALL immediately force: synchroniser=0, FSM=IDLE, deb=0, count=0, COUNT=0, RD_ACK=0, ALARM=0, LVL=0, RD_REQ history=0.
REQ-027 MR asserted mid-debounce or mid-handshake SHALL discard the pending event or acknowledge; there SHALL be no RD_ACK after release without a new RD_REQ rise.

Configuration
REQ-028 With SENSOR_MONITOR_SAT_EN defined, the count SHALL saturate at 2^CNT_W-1 and an extra output OVF (1 bit, sticky, cleared by CLR/MR) SHALL assert on the first blocked increment.
REQ-029 Without SENSOR_MONITOR_SAT_EN, the count SHALL wrap modulo 2^CNT_W, ALARM SHALL remain set across the wrap, and the OVF port SHALL not exist.

Structure
REQ-030 The package sensor_monitor_pkg SHALL hold the FSM state encoding (2 bits) and the default parameter constants.
REQ-031 The synchroniser SHALL be a separate sub-module, sensor_sync (2 flops, async reset to 0); all other logic SHALL live in sensor_monitor.

Verification
REQ-032 DEB_LEN=4: Z_IN high for 10 cycles -> LVL=1 after edge 6, count 0->1.
REQ-033 Z_IN 3-cycle high pulses separated by 5 low cycles, repeated 5 times -> count stays 0 and LVL stays 0.
REQ-034 10 clean events with ALARM_TH=10 -> ALARM rises on the 10th increment; CLR -> count=0 and ALARM=0 next edge; CLR coincident with an event -> count=0.
REQ-035 Count=7 with RD_REQ rising while an event lands -> COUNT=7, RD_ACK a single pulse, count=8; RD_REQ held 20 cycles -> no second RD_ACK.
REQ-036 CNT_W=3 with 9 events -> with SENSOR_MONITOR_SAT_EN: count=7 and OVF=1; without it: count=1.
REQ-037 MR pulsed during RISE_CHK (deb=2) and during an RD_ACK cycle -> all outputs 0 immediately, and no event or acknowledge after release.
